// File: rtl/instruction_fetch_loader.sv
// Instruction buffer loader/fetcher feeding a single-cycle core: load over valid/ready, then serve buf[pc>>2].
// Optional: define FETCH_HALT_ON_EBREAK_EN to turn a fetched EBREAK into a NOP and halt.
module instruction_fetch_loader #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 64,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  start,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instr_valid,
  output logic                  core_run,
  output logic                  halted,
  output logic [ADDR_WIDTH:0]   prog_len,
  output logic                  err_overflow
);

  typedef enum logic [1:0] {IDLE, READY, RUN, HALT} state_t;

  state_t                state, nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] fetch_word;
  logic                  beat, at_end, in_prog, is_ebreak;

  // clear outranks a coincident load beat, so the beat is dropped here
  assign beat       = load_valid && load_ready && !clear;
  assign at_end     = (wr_ptr == (ADDR_WIDTH+1)'(DEPTH-1));
  assign idx        = pc[ADDR_WIDTH+1:2];
  assign fetch_word = mem[idx];
  // misaligned PCs count as outside the program
  assign in_prog    = (pc[1:0] == 2'b00) && ((pc >> 2) < DATA_WIDTH'(wr_ptr));
`ifdef FETCH_HALT_ON_EBREAK_EN
  assign is_ebreak  = in_prog && (fetch_word == 32'h0010_0073);
`else
  assign is_ebreak  = 1'b0;
`endif
  assign prog_len   = wr_ptr;

  always_ff @(posedge clk) begin
    if (beat) mem[wr_ptr[ADDR_WIDTH-1:0]] <= load_data;
  end

  // wr_ptr stops at DEPTH because the FSM leaves IDLE on the DEPTH-th beat
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr       <= '0;
      err_overflow <= 1'b0;
    end else if (beat) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (at_end && !load_last) err_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (clear) nxt = IDLE;
    else begin
      case (state)
        IDLE:  if (beat && (load_last || at_end)) nxt = READY;
        READY: if (start) nxt = RUN;
        RUN:   if (!in_prog || is_ebreak) nxt = HALT;
        HALT:  if (start) nxt = RUN;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    load_ready  = (state == IDLE);
    core_run    = (state == RUN);
    halted      = (state == HALT);
    instr_valid = (state == RUN) && in_prog && !is_ebreak;
    instruction = instr_valid ? fetch_word : NOP_INSTR;
  end

endmodule

// File: tb/tb_instruction_fetch_loader.sv
// Directed bench for instruction_fetch_loader; expectations are hand-computed constants.
module tb_instruction_fetch_loader;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, load_valid, load_last, start, clear;
  logic [31:0] load_data, pc;
  logic        load_ready, instr_valid, core_run, halted, err_overflow;
  logic [31:0] instruction;
  logic [6:0]  prog_len;

  int errs = 0;
  int checks = 0;
  int acc;

  instruction_fetch_loader dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .start(start), .clear(clear),
    .pc(pc), .instruction(instruction), .instr_valid(instr_valid),
    .core_run(core_run), .halted(halted), .prog_len(prog_len),
    .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h want %08h", tag, act, exp);
    end
  endtask

  // inputs change 1 time unit after the edge, outputs are sampled 1 unit later
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_valid = 1'b0; load_last = 1'b0; start = 1'b0; clear = 1'b0;
    load_data = '0; pc = '0;
    tick(); tick();
    rst = 1'b0; settle();
    chk("rst_ready",   32'(load_ready), 32'd1);
    chk("rst_len",     32'(prog_len),   32'd0);
    chk("rst_run",     32'(core_run),   32'd0);
    chk("rst_instr",   instruction,     NOP);
    chk("rst_halted",  32'(halted),     32'd0);
    chk("rst_ivalid",  32'(instr_valid),32'd0);
    chk("rst_ovf",     32'(err_overflow),32'd0);

    // overflow: valid held for 65 words, only 64 fit
    acc = 0;
    load_valid = 1'b1;
    for (int i = 0; i < 65; i++) begin
      load_data = 32'hA000_0000 + 32'(i);
      if (load_ready) acc++;
      tick();
    end
    load_valid = 1'b0; settle();
    chk("ovf_accepted", 32'(acc),          32'd64);
    chk("ovf_flag",     32'(err_overflow), 32'd1);
    chk("ovf_len",      32'(prog_len),     32'd64);
    chk("ovf_ready",    32'(load_ready),   32'd0);
    chk("ovf_run_pre",  32'(core_run),     32'd0);
    pc = 32'd0;
    pulse_start(); settle();
    chk("ovf_run",      32'(core_run),     32'd1);
    chk("ovf_w0",       instruction,       32'hA000_0000);
    pc = 32'd252; settle();
    chk("ovf_w63",      instruction,       32'hA000_003F);
    pc = 32'd6; settle();
    chk("misalign_nop", instruction,       NOP);
    chk("misalign_iv",  32'(instr_valid),  32'd0);
    tick();
    chk("misalign_halt",32'(halted),       32'd1);
    chk("halt_run",     32'(core_run),     32'd0);

    // start and clear together in HALT: clear wins
    start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0; settle();
    chk("clr_ready",    32'(load_ready),   32'd1);
    chk("clr_run",      32'(core_run),     32'd0);
    chk("clr_ovf",      32'(err_overflow), 32'd0);
    chk("clr_len",      32'(prog_len),     32'd0);

    // three-word program
    load_word(32'h0000_0513, 1'b0);
    load_word(32'h0010_0593, 1'b0);
    load_word(32'h00B5_0633, 1'b1);
    settle();
    chk("p3_len",       32'(prog_len),     32'd3);
    chk("p3_ready",     32'(load_ready),   32'd0);
    pc = 32'd0;
    pulse_start(); settle();
    chk("p3_run",       32'(core_run),     32'd1);
    chk("p3_i0",        instruction,       32'h0000_0513);
    chk("p3_v0",        32'(instr_valid),  32'd1);
    tick(); pc = 32'd4; settle();
    chk("p3_i1",        instruction,       32'h0010_0593);
    tick(); pc = 32'd8; settle();
    chk("p3_i2",        instruction,       32'h00B5_0633);
    chk("p3_v2",        32'(instr_valid),  32'd1);
    tick(); pc = 32'd12; settle();
    chk("p3_end_nop",   instruction,       NOP);
    chk("p3_end_iv",    32'(instr_valid),  32'd0);
    chk("p3_end_run",   32'(core_run),     32'd1);
    tick();
    chk("p3_halted",    32'(halted),       32'd1);
    chk("p3_halt_nop",  instruction,       NOP);

    // reset in the middle of a 10-word load
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 5; i++) load_word(32'hB000_0000 + 32'(i), 1'b0);
    settle();
    chk("mid_len5",     32'(prog_len),     32'd5);
    rst = 1'b1; tick(); rst = 1'b0; settle();
    chk("mid_len0",     32'(prog_len),     32'd0);
    chk("mid_ready",    32'(load_ready),   32'd1);
    pulse_start(); settle();
    chk("mid_norun",    32'(core_run),     32'd0);
    chk("mid_ready2",   32'(load_ready),   32'd1);

    // EBREAK handling
    load_word(32'h0000_0513, 1'b0);
    load_word(32'h0010_0073, 1'b0);
    load_word(32'h0010_0593, 1'b1);
    pc = 32'd0;
    pulse_start(); settle();
    chk("eb_i0",        instruction,       32'h0000_0513);
    tick(); pc = 32'd4; settle();
`ifdef FETCH_HALT_ON_EBREAK_EN
    chk("eb_nop",       instruction,       NOP);
    chk("eb_iv",        32'(instr_valid),  32'd0);
    tick();
    chk("eb_halted",    32'(halted),       32'd1);
`else
    chk("eb_pass",      instruction,       32'h0010_0073);
    chk("eb_iv",        32'(instr_valid),  32'd1);
    tick();
    chk("eb_nohalt",    32'(halted),       32'd0);
    pc = 32'd8; settle();
    chk("eb_i2",        instruction,       32'h0010_0593);
    tick(); pc = 32'd12; settle();
    chk("eb_end_nop",   instruction,       NOP);
    tick();
    chk("eb_halted",    32'(halted),       32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
